// File: rtl/npu_seq_pkg.sv
// Shared types and constants for the NPU control sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package npu_seq_pkg;

    // Config tag offsets, relative to the first non-weight tag (NUM_PE)
    localparam int IN_FMT_OFS   = 0;
    localparam int OUT_FMT_OFS  = 1;
    localparam int IN_CNT_OFS   = 2;
    localparam int OUT_CNT_OFS  = 3;
    localparam int SCHED_OFS    = 4;
    localparam int OFFSET_OFS   = 5;
    localparam int BATCH_OFS    = 6;
    localparam int START_OFS    = 7;
    localparam int SOFT_RST_OFS = 8;

    // Batch count used after reset, after soft reset, and in place of a zero payload
    localparam int BATCH_DEFAULT = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIG  = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_STALL   = 2'd3
    } state_t;

endpackage

// File: rtl/npu_cfg_decode.sv
// Registered config-tag decoder: one-hot target strobes, payload, soft-reset and error pulses.
// Latency: a word popped in cycle t produces its strobe and cfg_dout in cycle t+1.
// Backpressure: none; decodes whatever the sequencer pops, one word per cycle.
module npu_cfg_decode
    import npu_seq_pkg::*;
#(
    parameter int NUM_PE = 8,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 5
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    pop,
    input  logic [TAG_W+DATA_W-1:0] cfg_din,
    output logic [DATA_W-1:0]       cfg_dout,
    output logic [NUM_PE-1:0]       weight_wr_en,
    output logic                    in_fmt_wr_en,
    output logic                    out_fmt_wr_en,
    output logic                    sched_wr_en,
    output logic                    offset_wr_en,
    output logic                    npu_rst,
    output logic                    err
);

    int                tag_i;
    logic [NUM_PE-1:0] weight_nxt;

    assign tag_i = int'(cfg_din[TAG_W+DATA_W-1:DATA_W]);

    // One-hot weight strobe for tags below NUM_PE
    always_comb begin
        weight_nxt = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            weight_nxt[i] = pop && (tag_i == i);
        end
    end

    // Register the decoded strobes; payload only updates on a pop
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cfg_dout      <= '0;
            weight_wr_en  <= '0;
            in_fmt_wr_en  <= 1'b0;
            out_fmt_wr_en <= 1'b0;
            sched_wr_en   <= 1'b0;
            offset_wr_en  <= 1'b0;
            npu_rst       <= 1'b0;
            err           <= 1'b0;
        end else begin
            weight_wr_en  <= weight_nxt;
            in_fmt_wr_en  <= pop && (tag_i == NUM_PE + IN_FMT_OFS);
            out_fmt_wr_en <= pop && (tag_i == NUM_PE + OUT_FMT_OFS);
            sched_wr_en   <= pop && (tag_i == NUM_PE + SCHED_OFS);
            offset_wr_en  <= pop && (tag_i == NUM_PE + OFFSET_OFS);
            npu_rst       <= pop && (tag_i == NUM_PE + SOFT_RST_OFS);
            err           <= pop && (tag_i > NUM_PE + SOFT_RST_OFS);
            if (pop) begin
                cfg_dout <= cfg_din[DATA_W-1:0];
            end
        end
    end

endmodule

// File: rtl/npu_sequencer.sv
// NPU control sequencer: config-word dispatch plus batched invocation control of input/output FIFOs.
// Latency: config strobe 1 cycle after pop; START to COMPUTE 1 cycle; inv_done 1 cycle after last grant.
// Backpressure: empty input FIFO or full output FIFO on a live request stalls the whole cycle (all-or-nothing).
module npu_sequencer
    import npu_seq_pkg::*;
#(
    parameter int NUM_PE = 8,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [TAG_W+DATA_W-1:0] cfg_din,
    input  logic                    cfg_empty,
    output logic                    cfg_rd_en,
    output logic [DATA_W-1:0]       cfg_dout,
    output logic [NUM_PE-1:0]       weight_wr_en,
    output logic                    in_fmt_wr_en,
    output logic                    out_fmt_wr_en,
    output logic                    sched_wr_en,
    output logic                    offset_wr_en,
    output logic                    npu_rst,
    input  logic                    in_fifo_empty,
    input  logic                    out_fifo_full,
    input  logic                    sched_in_req,
    input  logic                    sched_out_req,
    output logic                    in_fifo_rd_en,
    output logic                    out_fifo_wr_en,
    output logic                    state_idle,
    output logic                    state_config,
    output logic                    state_compute,
    output logic                    state_stall,
    output logic                    inv_done,
    output logic                    cfg_err
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] in_cnt, out_cnt, batch_cnt;
    logic [CNT_W-1:0] in_rem, out_rem, batch_rem;
    logic [CNT_W-1:0] in_rem_nxt, out_rem_nxt, pay_cnt;
    logic             cfg_err_q, dec_err;
    int               tag_i;
    logic             ld_in, ld_out, ld_batch, start_pop, soft_pop, start_ok, start_bad;
    logic             in_live, out_live, blocked, grant, inv_end, more_batches;

    npu_cfg_decode #(
        .NUM_PE (NUM_PE),
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) u_dec (
        .CLK           (CLK),
        .RST           (RST),
        .pop           (cfg_rd_en),
        .cfg_din       (cfg_din),
        .cfg_dout      (cfg_dout),
        .weight_wr_en  (weight_wr_en),
        .in_fmt_wr_en  (in_fmt_wr_en),
        .out_fmt_wr_en (out_fmt_wr_en),
        .sched_wr_en   (sched_wr_en),
        .offset_wr_en  (offset_wr_en),
        .npu_rst       (npu_rst),
        .err           (dec_err)
    );

    // Counter-affecting tags are acted on in the pop cycle itself
    assign tag_i     = int'(cfg_din[TAG_W+DATA_W-1:DATA_W]);
    assign pay_cnt   = cfg_din[CNT_W-1:0];
    assign ld_in     = cfg_rd_en && (tag_i == NUM_PE + IN_CNT_OFS);
    assign ld_out    = cfg_rd_en && (tag_i == NUM_PE + OUT_CNT_OFS);
    assign ld_batch  = cfg_rd_en && (tag_i == NUM_PE + BATCH_OFS);
    assign start_pop = cfg_rd_en && (tag_i == NUM_PE + START_OFS);
    assign soft_pop  = cfg_rd_en && (tag_i == NUM_PE + SOFT_RST_OFS);
    assign start_ok  = start_pop && (in_cnt != '0) && (out_cnt != '0);
    assign start_bad = start_pop && !start_ok;

    // A request only counts while work of that kind remains
    assign in_live      = sched_in_req && (in_rem != '0);
    assign out_live     = sched_out_req && (out_rem != '0);
    assign blocked      = (in_live && in_fifo_empty) || (out_live && out_fifo_full);
    assign grant        = (state == ST_COMPUTE) && !blocked;
    assign in_rem_nxt   = in_rem - CNT_W'(in_live);
    assign out_rem_nxt  = out_rem - CNT_W'(out_live);
    assign inv_end      = grant && (in_live || out_live) && (in_rem_nxt == '0) && (out_rem_nxt == '0);
    assign more_batches = batch_rem > CNT_W'(1);
    assign cfg_err      = cfg_err_q | dec_err;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (!cfg_empty) state_nxt = ST_CONFIG;
            ST_CONFIG:  if (start_ok) state_nxt = ST_COMPUTE;
            ST_COMPUTE: begin
                if (blocked) begin
                    state_nxt = ST_STALL;
                end else if (inv_end && !more_batches) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_STALL:   if (!blocked) state_nxt = ST_COMPUTE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state; FIFO enables only in an unblocked COMPUTE cycle
    always_comb begin
        state_idle     = (state == ST_IDLE);
        state_config   = (state == ST_CONFIG);
        state_compute  = (state == ST_COMPUTE);
        state_stall    = (state == ST_STALL);
        cfg_rd_en      = (state == ST_CONFIG) && !cfg_empty;
        in_fifo_rd_en  = grant && in_live;
        out_fifo_wr_en = grant && out_live;
    end

    // Config counts, remaining counts, completion pulse and sticky error
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            in_cnt    <= '0;
            out_cnt   <= '0;
            batch_cnt <= CNT_W'(BATCH_DEFAULT);
            in_rem    <= '0;
            out_rem   <= '0;
            batch_rem <= '0;
            inv_done  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            inv_done <= inv_end;
            if (start_bad || dec_err) begin
                cfg_err_q <= 1'b1;
            end
            if (soft_pop) begin
                in_cnt    <= '0;
                out_cnt   <= '0;
                batch_cnt <= CNT_W'(BATCH_DEFAULT);
            end
            if (ld_in) begin
                in_cnt <= pay_cnt;
            end
            if (ld_out) begin
                out_cnt <= pay_cnt;
            end
            if (ld_batch) begin
                batch_cnt <= (pay_cnt == '0) ? CNT_W'(BATCH_DEFAULT) : pay_cnt;
            end
            if (start_ok) begin
                in_rem    <= in_cnt;
                out_rem   <= out_cnt;
                batch_rem <= batch_cnt;
            end else if (inv_end && more_batches) begin
                in_rem    <= in_cnt;
                out_rem   <= out_cnt;
                batch_rem <= batch_rem - CNT_W'(1);
            end else if (grant) begin
                in_rem  <= in_rem_nxt;
                out_rem <= out_rem_nxt;
            end
        end
    end

endmodule

// File: tb/tb_npu_sequencer.sv
// Directed bench for npu_sequencer: config strobes, invocations, stalls, batching, errors, reset.
// Latency: checks use hand-derived cycle positions relative to each pop/START.
// Backpressure: FIFO empty/full windows are driven at fixed cycle offsets.
module tb_npu_sequencer;

    localparam int NUM_PE = 8;
    localparam int DATA_W = 16;
    localparam int TAG_W  = 5;
    localparam int CNT_W  = 8;

    localparam int T_IN_FMT  = NUM_PE + 0;
    localparam int T_IN_CNT  = NUM_PE + 2;
    localparam int T_OUT_CNT = NUM_PE + 3;
    localparam int T_BATCH   = NUM_PE + 6;
    localparam int T_START   = NUM_PE + 7;
    localparam int T_SOFT    = NUM_PE + 8;
    localparam int T_BAD     = NUM_PE + 9;

    logic                    CLK, RST;
    logic [TAG_W+DATA_W-1:0] cfg_din;
    logic                    cfg_empty, cfg_rd_en;
    logic [DATA_W-1:0]       cfg_dout;
    logic [NUM_PE-1:0]       weight_wr_en;
    logic                    in_fmt_wr_en, out_fmt_wr_en, sched_wr_en, offset_wr_en, npu_rst;
    logic                    in_fifo_empty, out_fifo_full, sched_in_req, sched_out_req;
    logic                    in_fifo_rd_en, out_fifo_wr_en;
    logic                    state_idle, state_config, state_compute, state_stall;
    logic                    inv_done, cfg_err;

    int checks   = 0;
    int failures = 0;

    npu_sequencer #(
        .NUM_PE (NUM_PE),
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .cfg_din        (cfg_din),
        .cfg_empty      (cfg_empty),
        .cfg_rd_en      (cfg_rd_en),
        .cfg_dout       (cfg_dout),
        .weight_wr_en   (weight_wr_en),
        .in_fmt_wr_en   (in_fmt_wr_en),
        .out_fmt_wr_en  (out_fmt_wr_en),
        .sched_wr_en    (sched_wr_en),
        .offset_wr_en   (offset_wr_en),
        .npu_rst        (npu_rst),
        .in_fifo_empty  (in_fifo_empty),
        .out_fifo_full  (out_fifo_full),
        .sched_in_req   (sched_in_req),
        .sched_out_req  (sched_out_req),
        .in_fifo_rd_en  (in_fifo_rd_en),
        .out_fifo_wr_en (out_fifo_wr_en),
        .state_idle     (state_idle),
        .state_config   (state_config),
        .state_compute  (state_compute),
        .state_stall    (state_stall),
        .inv_done       (inv_done),
        .cfg_err        (cfg_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one word at the FWFT head and wait for it to be popped; returns one cycle after the pop
    task automatic send(input int tag, input int pay);
        logic got;
        got       = 1'b0;
        cfg_din   = {TAG_W'(tag), DATA_W'(pay)};
        cfg_empty = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (cfg_rd_en) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("send_pop", {31'd0, got}, 32'd1);
        tick();
        cfg_empty = 1'b1;
    endtask

    // Run one START'ed job with requests held high; mode 1/2 holds input-empty/output-full during k=2..5
    task automatic run_inv(input int mode, output int nrd, output int nwr, output int ndone,
                           output int nstall, output int nwin, output int ncomp,
                           output int last_k, output logic idle_seen);
        nrd = 0; nwr = 0; ndone = 0; nstall = 0; nwin = 0; ncomp = 0; last_k = -1;
        idle_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            in_fifo_empty = (mode == 1) && (k >= 2) && (k < 6);
            out_fifo_full = (mode == 2) && (k >= 2) && (k < 6);
            #1;
            if (in_fifo_rd_en) nrd++;
            if (out_fifo_wr_en) nwr++;
            if (inv_done) begin
                ndone++;
                last_k = k;
            end
            if (state_stall) nstall++;
            if (state_compute) ncomp++;
            if ((k >= 2) && (k <= 6) && (in_fifo_rd_en || out_fifo_wr_en)) nwin++;
            if (state_idle) begin
                idle_seen = 1'b1;
                break;
            end
            tick();
        end
        in_fifo_empty = 1'b0;
        out_fifo_full = 1'b0;
    endtask

    initial begin
        int          nrd, nwr, ndone, nstall, nwin, ncomp, last_k;
        logic        idle_seen;
        logic [31:0] e;
        logic [3:0]  strobe_exp [4];
        int          strobe_ofs [4];

        RST = 1'b0; cfg_din = '0; cfg_empty = 1'b1;
        in_fifo_empty = 1'b0; out_fifo_full = 1'b0;
        sched_in_req = 1'b1; sched_out_req = 1'b1;

        // Reset state
        #3;
        chk("rst_state", {28'd0, state_idle, state_config, state_compute, state_stall}, 32'h8);
        chk("rst_strobes", {19'd0, weight_wr_en, in_fmt_wr_en, out_fmt_wr_en, sched_wr_en, offset_wr_en, npu_rst}, 32'd0);
        chk("rst_misc", {27'd0, cfg_rd_en, in_fifo_rd_en, out_fifo_wr_en, inv_done, cfg_err}, 32'd0);
        chk("rst_dout", {16'd0, cfg_dout}, 32'd0);
        #10;
        RST = 1'b1;
        tick();

        // Back-to-back weight writes
        cfg_din = {TAG_W'(0), DATA_W'(16'h1000)};
        cfg_empty = 1'b0;
        #1;
        chk("idle_no_pop", {31'd0, cfg_rd_en}, 32'd0);
        tick();
        for (int i = 0; i < NUM_PE; i++) begin
            cfg_din = {TAG_W'(i), DATA_W'(16'h1000 + i)};
            #1;
            chk("wt_pop", {31'd0, cfg_rd_en}, 32'd1);
            e = (i > 0) ? (32'd1 << (i - 1)) : 32'd0;
            chk("wt_strobe", {24'd0, weight_wr_en}, e);
            if (i > 0) chk("wt_dout", {16'd0, cfg_dout}, 32'h1000 + 32'(i - 1));
            tick();
        end
        cfg_empty = 1'b1;
        #1;
        chk("wt_last_strobe", {24'd0, weight_wr_en}, 32'h80);
        chk("wt_last_dout", {16'd0, cfg_dout}, 32'h1007);
        chk("wt_drain_pop", {31'd0, cfg_rd_en}, 32'd0);
        tick();
        chk("wt_strobe_off", {24'd0, weight_wr_en}, 32'd0);

        // Single invocation: 3 in, 2 out
        send(T_IN_CNT, 3);
        send(T_OUT_CNT, 2);
        send(T_START, 0);
        chk("start_lat", {31'd0, state_compute}, 32'd1);
        run_inv(0, nrd, nwr, ndone, nstall, nwin, ncomp, last_k, idle_seen);
        chk("inv_rd", nrd, 3);
        chk("inv_wr", nwr, 2);
        chk("inv_done_cnt", ndone, 1);
        chk("inv_done_k", last_k, 3);
        chk("inv_idle", {31'd0, idle_seen}, 32'd1);

        // Stall on empty input FIFO, then on full output FIFO
        for (int m = 1; m <= 2; m++) begin
            send(T_IN_CNT, 4);
            send(T_OUT_CNT, 4);
            send(T_START, 0);
            run_inv(m, nrd, nwr, ndone, nstall, nwin, ncomp, last_k, idle_seen);
            chk("stall_cycles", nstall, 4);
            chk("stall_no_en", nwin, 0);
            chk("stall_rd", nrd, 4);
            chk("stall_wr", nwr, 4);
            chk("stall_done_k", last_k, 9);
            chk("stall_idle", {31'd0, idle_seen}, 32'd1);
        end

        // Batch of three single-word invocations
        send(T_BATCH, 3);
        send(T_IN_CNT, 1);
        send(T_OUT_CNT, 1);
        send(T_START, 0);
        run_inv(0, nrd, nwr, ndone, nstall, nwin, ncomp, last_k, idle_seen);
        chk("batch_done", ndone, 3);
        chk("batch_comp", ncomp, 3);
        chk("batch_rd", nrd, 3);
        chk("batch_done_k", last_k, 3);
        chk("batch_idle", {31'd0, idle_seen}, 32'd1);

        // Soft reset pulse
        send(T_SOFT, 0);
        chk("soft_pulse", {31'd0, npu_rst}, 32'd1);
        chk("soft_in_cfg", {31'd0, state_config}, 32'd1);
        chk("soft_no_err", {31'd0, cfg_err}, 32'd0);
        tick();
        chk("soft_pulse_end", {31'd0, npu_rst}, 32'd0);

        // START with zero output count is rejected
        send(T_OUT_CNT, 0);
        send(T_IN_CNT, 2);
        send(T_START, 0);
        chk("start_bad_err", {31'd0, cfg_err}, 32'd1);
        chk("start_bad_state", {28'd0, state_idle, state_config, state_compute, state_stall}, 32'h4);
        tick();
        chk("start_bad_hold", {31'd0, state_config}, 32'd1);

        // Batch count back to 1 after soft reset: exactly one completion
        send(T_IN_CNT, 1);
        send(T_OUT_CNT, 1);
        send(T_START, 0);
        run_inv(0, nrd, nwr, ndone, nstall, nwin, ncomp, last_k, idle_seen);
        chk("soft_batch_done", ndone, 1);
        chk("soft_batch_k", last_k, 1);
        chk("soft_batch_idle", {31'd0, idle_seen}, 32'd1);

        // Asynchronous reset in the middle of a stall
        send(T_IN_CNT, 2);
        send(T_OUT_CNT, 2);
        send(T_START, 0);
        in_fifo_empty = 1'b1;
        #1;
        chk("pre_rst_block", {30'd0, in_fifo_rd_en, out_fifo_wr_en}, 32'd0);
        tick();
        chk("pre_rst_stall", {31'd0, state_stall}, 32'd1);
        #1;
        RST = 1'b0;
        #1;
        chk("arst_state", {28'd0, state_idle, state_config, state_compute, state_stall}, 32'h8);
        chk("arst_en", {27'd0, cfg_rd_en, in_fifo_rd_en, out_fifo_wr_en, inv_done, cfg_err}, 32'd0);
        #1;
        in_fifo_empty = 1'b0;
        RST = 1'b1;
        tick();
        chk("post_rst_idle", {31'd0, state_idle}, 32'd1);

        // Unknown tag: popped, no strobe, sticky error
        send(T_BAD, 16'h1234);
        chk("bad_err", {31'd0, cfg_err}, 32'd1);
        chk("bad_no_strobe", {19'd0, weight_wr_en, in_fmt_wr_en, out_fmt_wr_en, sched_wr_en, offset_wr_en, npu_rst}, 32'd0);
        tick();
        chk("bad_err_sticky", {31'd0, cfg_err}, 32'd1);

        // Fresh config after reset: single-target strobes with their payloads
        strobe_ofs[0] = 0; strobe_exp[0] = 4'b1000;
        strobe_ofs[1] = 1; strobe_exp[1] = 4'b0100;
        strobe_ofs[2] = 4; strobe_exp[2] = 4'b0010;
        strobe_ofs[3] = 5; strobe_exp[3] = 4'b0001;
        for (int j = 0; j < 4; j++) begin
            send(T_IN_FMT + strobe_ofs[j], 16'h5A00 + strobe_ofs[j]);
            chk("tgt_strobe", {28'd0, in_fmt_wr_en, out_fmt_wr_en, sched_wr_en, offset_wr_en}, {28'd0, strobe_exp[j]});
            chk("tgt_dout", {16'd0, cfg_dout}, 32'h5A00 + 32'(strobe_ofs[j]));
            chk("tgt_no_wt", {24'd0, weight_wr_en}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

endmodule
